// File: rtl/piezo_pkg.sv
// Shared note/tune codes, nominal half-periods and tune sequences for the piezo
// tone decoder and anything that drives it.
package piezo_pkg;

  typedef enum logic [2:0] {
    NOTE_NONE = 3'd0,
    NOTE_G6   = 3'd1,
    NOTE_C7   = 3'd2,
    NOTE_E7   = 3'd3,
    NOTE_G7   = 3'd4
  } note_t;

  typedef enum logic [2:0] {
    TUNE_NONE    = 3'd0,
    TUNE_STEER   = 3'd1,
    TUNE_BATT    = 3'd2,
    TUNE_FAST    = 3'd3,
    TUNE_UNKNOWN = 3'd4
  } tune_t;

  localparam int unsigned PERIOD_W     = 16;
  localparam int unsigned DUR_W        = 26;
  localparam int unsigned MATCH_W      = 3;
  localparam int unsigned NOTE_MATCHES = 4;
  localparam int unsigned HIST_LEN     = 6;
  localparam int unsigned HIST_W       = HIST_LEN * 3;
  localparam int unsigned FAST_DIV     = 64;

  // Full-speed nominal half-periods in 50 MHz cycles
  localparam int unsigned NOM_G6 = 15943;
  localparam int unsigned NOM_C7 = 11945;
  localparam int unsigned NOM_E7 = 9485;
  localparam int unsigned NOM_G7 = 7969;

  // Oldest note in the most significant slot
  localparam logic [HIST_W-1:0] STEER_SEQ =
    {NOTE_G6, NOTE_C7, NOTE_E7, NOTE_G7, NOTE_E7, NOTE_G7};
  localparam logic [HIST_W-1:0] BATT_SEQ =
    {NOTE_G7, NOTE_E7, NOTE_G7, NOTE_E7, NOTE_C7, NOTE_G6};

  function automatic int unsigned nominal(input note_t n, input bit fast);
    int unsigned nom;
    case (n)
      NOTE_G6: nom = NOM_G6;
      NOTE_C7: nom = NOM_C7;
      NOTE_E7: nom = NOM_E7;
      NOTE_G7: nom = NOM_G7;
      default: nom = 0;
    endcase
    return fast ? nom / FAST_DIV : nom;
  endfunction

  // Silence is twice the widest window's upper bound (G6)
  function automatic int unsigned timeout_cycles(input bit fast);
    int unsigned nom;
    nom = nominal(NOTE_G6, fast);
    return 2 * (nom + nom / 16);
  endfunction

  function automatic logic in_window(input logic [PERIOD_W-1:0] p, input int unsigned nom);
    int unsigned lo;
    int unsigned hi;
    lo = nom - nom / 16;
    hi = nom + nom / 16;
    return (32'(p) >= lo) && (32'(p) <= hi);
  endfunction

  function automatic note_t classify(input logic [PERIOD_W-1:0] p, input bit fast);
    note_t n;
    if (in_window(p, nominal(NOTE_G6, fast)))      n = NOTE_G6;
    else if (in_window(p, nominal(NOTE_C7, fast))) n = NOTE_C7;
    else if (in_window(p, nominal(NOTE_E7, fast))) n = NOTE_E7;
    else if (in_window(p, nominal(NOTE_G7, fast))) n = NOTE_G7;
    else                                           n = NOTE_NONE;
    return n;
  endfunction

  function automatic tune_t decode_tune(input logic [HIST_W-1:0] h);
    tune_t t;
    if (h == STEER_SEQ)     t = TUNE_STEER;
    else if (h == BATT_SEQ) t = TUNE_BATT;
    else                    t = TUNE_UNKNOWN;
    return t;
  endfunction

endpackage

// File: rtl/piezo_period_meas.sv
// Input registering, edge detection, half-period counting and note classification
// of the positive piezo leg.
module piezo_period_meas
  import piezo_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                piezo,
  input  logic                piezo_n,
  output logic                piezo_q,
  output logic                piezo_n_q,
  output logic                edge_vld,
  output logic [PERIOD_W-1:0] period,
  output note_t               cls
);

  logic                piezo_d;
  logic [PERIOD_W-1:0] cnt;
  logic                edge_c;

  assign edge_c = piezo_q ^ piezo_d;

  // Counter holds cycles since the last edge; its value on an edge is the half-period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piezo_q   <= 1'b0;
      piezo_n_q <= 1'b0;
      piezo_d   <= 1'b0;
      edge_vld  <= 1'b0;
      cnt       <= '0;
      period    <= '0;
      cls       <= NOTE_NONE;
    end else begin
      piezo_q   <= piezo;
      piezo_n_q <= piezo_n;
      piezo_d   <= piezo_q;
      edge_vld  <= edge_c;
      if (edge_c) begin
        cnt    <= PERIOD_W'(1);
        period <= cnt;
        cls    <= classify(cnt, FAST_SIM != 0);
      end else if (cnt != '1) begin
        cnt <= cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/piezo_decoder.sv
// Decodes a differential piezo tone drive into notes (code + duration) and
// recognises the tunes formed by consecutive notes.
module piezo_decoder
  import piezo_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             piezo,
  input  logic             piezo_n,
  output logic             note_vld,
  output logic [2:0]       note_code,
  output logic [DUR_W-1:0] note_dur,
  output logic             tune_vld,
  output logic [2:0]       tune_code,
  output logic             diff_err
);

  localparam int unsigned TIMEOUT = timeout_cycles(FAST_SIM != 0);

  localparam logic [1:0] SILENT  = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] NOTE    = 2'd2;

  logic                piezo_q;
  logic                piezo_n_q;
  logic                edge_vld;
  logic [PERIOD_W-1:0] period;
  note_t               cls;

  piezo_period_meas #(.FAST_SIM(FAST_SIM)) u_meas (
    .clk       (clk),
    .rst_n     (rst_n),
    .piezo     (piezo),
    .piezo_n   (piezo_n),
    .piezo_q   (piezo_q),
    .piezo_n_q (piezo_n_q),
    .edge_vld  (edge_vld),
    .period    (period),
    .cls       (cls)
  );

  logic [1:0]          state, state_nx;
  note_t               cand, cand_nx;
  note_t               cur, cur_nx;
  logic [MATCH_W-1:0]  match, match_nx;
  logic [DUR_W-1:0]    acc, acc_nx;
  logic [DUR_W-1:0]    dur, dur_nx;
  logic [DUR_W-1:0]    mark, mark_nx;
  logic [HIST_W-1:0]   hist, hist_nx, hist_shift;
  logic                fast_seen, fast_seen_nx;
  logic [PERIOD_W-1:0] idle, idle_nx;

  logic                note_vld_nx, tune_vld_nx, diff_err_nx;
  logic [2:0]          note_code_nx, tune_code_nx;
  logic [DUR_W-1:0]    note_dur_nx;

  logic                timeout_c, note_end_c, fast_c;
  logic [DUR_W-1:0]    period_ext, dur_inc;

  assign period_ext = DUR_W'(period);
  assign dur_inc    = (dur == '1) ? dur : dur + DUR_W'(1);
  assign timeout_c  = (state != SILENT) && !edge_vld && (idle == PERIOD_W'(TIMEOUT));

  // Next-state, note tracking and tune recognition
  always_comb begin
    state_nx     = state;
    cand_nx      = cand;
    cur_nx       = cur;
    match_nx     = match;
    acc_nx       = acc;
    dur_nx       = dur;
    mark_nx      = mark;
    fast_seen_nx = fast_seen;
    hist_shift   = hist;
    hist_nx      = hist;
    note_end_c   = 1'b0;
    fast_c       = 1'b0;
    note_vld_nx  = 1'b0;
    note_code_nx = note_code;
    note_dur_nx  = note_dur;
    tune_vld_nx  = 1'b0;
    tune_code_nx = tune_code;
    diff_err_nx  = diff_err | ((state == NOTE) && (piezo_q == piezo_n_q));
    idle_nx      = edge_vld ? PERIOD_W'(1) :
                   ((idle == '1) ? idle : idle + PERIOD_W'(1));

    case (state)
      SILENT: begin
        // The first edge has no preceding edge, so its period carries no class
        if (edge_vld) begin
          state_nx = ACQUIRE;
          cand_nx  = NOTE_NONE;
          match_nx = '0;
          acc_nx   = '0;
        end
      end
      ACQUIRE: begin
        if (timeout_c) begin
          state_nx = SILENT;
        end else if (edge_vld) begin
          if (cls == cand) begin
            if (match != '1) match_nx = match + MATCH_W'(1);
            acc_nx = acc + period_ext;
            if ((cand != NOTE_NONE) && (match == MATCH_W'(NOTE_MATCHES - 1))) begin
              state_nx = NOTE;
              cur_nx   = cand;
              dur_nx   = acc + period_ext;
              mark_nx  = acc + period_ext;
              fast_c   = (cand == NOTE_G6) && (hist[2:0] == NOTE_E7);
            end
          end else begin
            cand_nx  = cls;
            match_nx = MATCH_W'(1);
            acc_nx   = period_ext;
          end
        end
      end
      NOTE: begin
        dur_nx = dur_inc;
        // mark tracks the duration at the last edge of this note, so trailing
        // silence or the next note's first half-period is not counted
        if (timeout_c) begin
          note_end_c = 1'b1;
          state_nx   = SILENT;
        end else if (edge_vld) begin
          if (cls == cur) begin
            mark_nx = dur_inc;
          end else begin
            note_end_c = 1'b1;
            state_nx   = ACQUIRE;
            cand_nx    = cls;
            match_nx   = MATCH_W'(1);
            acc_nx     = period_ext;
          end
        end
      end
      default: state_nx = SILENT;
    endcase

    if (note_end_c) begin
      hist_shift   = {hist[HIST_W-4:0], cur};
      note_vld_nx  = 1'b1;
      note_code_nx = cur;
      note_dur_nx  = mark;
    end
    hist_nx = hist_shift;

    if (fast_c) begin
      tune_vld_nx  = 1'b1;
      tune_code_nx = TUNE_FAST;
      fast_seen_nx = 1'b1;
    end

    // Silence closes the episode; the note it ended is part of the history judged
    if (timeout_c) begin
      hist_nx      = '0;
      fast_seen_nx = 1'b0;
      if ((hist_shift != '0) && !fast_seen) begin
        tune_vld_nx  = 1'b1;
        tune_code_nx = decode_tune(hist_shift);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SILENT;
      cand      <= NOTE_NONE;
      cur       <= NOTE_NONE;
      match     <= '0;
      acc       <= '0;
      dur       <= '0;
      mark      <= '0;
      hist      <= '0;
      fast_seen <= 1'b0;
      idle      <= '0;
      note_vld  <= 1'b0;
      note_code <= '0;
      note_dur  <= '0;
      tune_vld  <= 1'b0;
      tune_code <= '0;
      diff_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      cand      <= cand_nx;
      cur       <= cur_nx;
      match     <= match_nx;
      acc       <= acc_nx;
      dur       <= dur_nx;
      mark      <= mark_nx;
      hist      <= hist_nx;
      fast_seen <= fast_seen_nx;
      idle      <= idle_nx;
      note_vld  <= note_vld_nx;
      note_code <= note_code_nx;
      note_dur  <= note_dur_nx;
      tune_vld  <= tune_vld_nx;
      tune_code <= tune_code_nx;
      diff_err  <= diff_err_nx;
    end
  end

endmodule

// File: tb/tb_piezo_decoder.sv
// Scoreboard bench for piezo_decoder: tone sequences push expected note/tune
// events, a negedge monitor pops and compares each pulse.
module tb_piezo_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        piezo = 1'b0;
  logic        piezo_n = 1'b1;
  logic        note_vld;
  logic [2:0]  note_code;
  logic [25:0] note_dur;
  logic        tune_vld;
  logic [2:0]  tune_code;
  logic        diff_err;

  piezo_decoder #(.FAST_SIM(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .piezo     (piezo),
    .piezo_n   (piezo_n),
    .note_vld  (note_vld),
    .note_code (note_code),
    .note_dur  (note_dur),
    .tune_vld  (tune_vld),
    .tune_code (tune_code),
    .diff_err  (diff_err)
  );

  always #5 clk = ~clk;

  // FAST_SIM half-periods and codes
  localparam int unsigned H_G6 = 249;
  localparam int unsigned H_C7 = 186;
  localparam int unsigned H_E7 = 148;
  localparam int unsigned H_G7 = 124;

  typedef struct {
    bit          is_tune;
    logic [2:0]  code;
    int unsigned dur;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned t4_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input longint act, input longint exp,
                            input longint tol);
    n_tests++;
    if ((act < exp - tol) || (act > exp + tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic void push_note(input int code, input int unsigned dur);
    exp_t e;
    e.is_tune = 1'b0; e.code = 3'(code); e.dur = dur; e.chk_lat = 1'b0;
    sb.push_back(e);
  endfunction

  function automatic void push_tune(input int code, input bit lat);
    exp_t e;
    e.is_tune = 1'b1; e.code = 3'(code); e.dur = 0; e.chk_lat = lat;
    sb.push_back(e);
  endfunction

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (note_vld) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_note: got code %0d dur %0d, expected no pulse",
                   note_code, note_dur);
        end else begin
          m_e = sb.pop_front();
          check("note_order", 0, longint'(m_e.is_tune));
          check("note_code", note_code, m_e.code);
          check_near("note_dur", note_dur, m_e.dur, 4);
        end
      end
      if (tune_vld) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_tune: got code %0d, expected no pulse", tune_code);
        end else begin
          m_e = sb.pop_front();
          check("tune_order", 1, longint'(m_e.is_tune));
          check("tune_code", tune_code, m_e.code);
          if (m_e.chk_lat) check("fast_latency", cyc, t4_cyc + 3);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // t toggles spaced h cycles; optional one-cycle non-complementary glitch
  task automatic tone(input int unsigned h, input int t, input int glitch_at);
    for (int i = 0; i < t; i++) begin
      piezo   = ~piezo;
      piezo_n = ~piezo;
      if (i == 4) t4_cyc = cyc;
      if (i == glitch_at) begin
        repeat (50) @(posedge clk);
        #1 piezo_n = piezo;
        @(posedge clk);
        #1 piezo_n = ~piezo;
        repeat (h - 51) @(posedge clk);
        #1;
      end else begin
        repeat (h) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic finish_test(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0) && (k < 2000)) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({"drain_", name}, sb.size(), 0);
    sb.delete();
    idle(100);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_note_vld"}, note_vld, 0);
    check({name, "_note_code"}, note_code, 0);
    check({name, "_note_dur"}, note_dur, 0);
    check({name, "_tune_vld"}, tune_vld, 0);
    check({name, "_tune_code"}, tune_code, 0);
    check({name, "_diff_err"}, diff_err, 0);
  endtask

  initial begin
    #(90_000 * 10);
    $display("FAIL watchdog: got no end of run, expected finish within 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(10);

    // Single G6 tone then silence
    push_note(1, 7968);
    push_tune(4, 1'b0);
    tone(H_G6, 33, -1);
    finish_test("single_g6");

    // Forward tune
    push_note(1, 1992); push_note(2, 2046); push_note(3, 2072);
    push_note(4, 3100); push_note(3, 1036); push_note(4, 4836);
    push_tune(1, 1'b0);
    tone(H_G6, 8, -1);  tone(H_C7, 11, -1); tone(H_E7, 14, -1);
    tone(H_G7, 25, -1); tone(H_E7, 7, -1);  tone(H_G7, 40, -1);
    finish_test("steer");

    // Reverse tune
    push_note(4, 4960); push_note(3, 1036); push_note(4, 3100);
    push_note(3, 2072); push_note(2, 2046); push_note(1, 1743);
    push_tune(2, 1'b0);
    tone(H_G7, 40, -1); tone(H_E7, 7, -1);  tone(H_G7, 25, -1);
    tone(H_E7, 14, -1); tone(H_C7, 11, -1); tone(H_G6, 8, -1);
    finish_test("batt");

    // E7 straight into G6: FAST when G6 locks, nothing more at silence
    push_note(1, 1992); push_note(2, 2046); push_note(3, 2072);
    push_tune(3, 1'b1);
    push_note(1, 2241);
    tone(H_G6, 8, -1); tone(H_C7, 11, -1); tone(H_E7, 14, -1); tone(H_G6, 10, -1);
    finish_test("fast");

    // Non-complementary legs for one cycle inside a C7 note
    check("diff_err_clear", diff_err, 0);
    push_note(2, 3534);
    push_tune(4, 1'b0);
    tone(H_C7, 20, 10);
    check("diff_err_set", diff_err, 1);
    finish_test("diff");
    check("diff_err_sticky", diff_err, 1);

    // Reset in the middle of a G6 note
    tone(H_G6, 10, -1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    idle(5);
    rst_n = 1'b1;
    idle(1000);
    check_outputs_zero("post_rst");
    check("post_rst_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
